// File: rtl/ibex_csr_rmw_ctrl.sv
// ibex_csr_rmw_ctrl: initiator-side access sequencer for the shadowed CSR
// primitive bank. Accepts read/write/set/clear requests, reads the addressed
// primitive, writes back the modified value with a one-cycle one-hot strobe
// and returns the old value. Shadow-mismatch errors abort the write, flag the
// response and pulse alert_o.
//
// Optional background scrub of the shadow-error flags: define IBEX_CSR_SCRUB_EN.
//
// Handshake: a request or response transfers on a rising clock edge where the
// valid and ready of that channel are both high. The valid side keeps its
// payload stable until that edge. req_ready_o is high only in IDLE, so at most
// one request is ever outstanding.
module ibex_csr_rmw_ctrl #(
  parameter int Width       = 32,
  parameter int NumCsr      = 8,
  parameter int ScrubPeriod = 256,
  localparam int AddrW      = $clog2(NumCsr)
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic [AddrW-1:0]        req_addr_i,
  input  logic [1:0]              req_op_i,
  input  logic [Width-1:0]        req_wdata_i,
  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output logic [Width-1:0]        rsp_rdata_o,
  output logic                    rsp_error_o,
  output logic [NumCsr-1:0]       csr_wr_en_o,
  output logic [Width-1:0]        csr_wr_data_o,
  input  logic [NumCsr*Width-1:0] csr_rd_data_i,
  input  logic [NumCsr-1:0]       csr_rd_error_i,
  output logic                    alert_o
);

  localparam logic [1:0] OpWrite = 2'b01;
  localparam logic [1:0] OpSet   = 2'b10;
  localparam logic [1:0] OpClear = 2'b11;

  // A bank needs at least two entries and a scrub period of at least two
  // cycles; smaller settings are not a supported configuration.
  if ((NumCsr < 2) || (ScrubPeriod < 2)) begin : gen_cfg_unsupported
  end

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_WRITE = 3'd2,
    ST_RESP  = 3'd3
`ifdef IBEX_CSR_SCRUB_EN
    , ST_SCRUB = 3'd4
`endif
  } state_e;

  state_e             state_q;
  logic [AddrW-1:0]   addr_q;
  logic [1:0]         op_q;
  logic [Width-1:0]   wdata_q;
  logic               req_ready_q;
  logic               rsp_valid_q;
  logic [Width-1:0]   rsp_rdata_q;
  logic               rsp_error_q;
  logic [NumCsr-1:0]  wr_en_q;
  logic [Width-1:0]   wr_data_q;
  logic               alert_q;

  logic               addr_ok;
  logic [Width-1:0]   sel_data;
  logic               sel_err;
  logic [Width-1:0]   new_val;
  logic               need_wr;

  // Select the addressed primitive; an index beyond the bank reads as zero.
  always_comb begin
    addr_ok  = 1'b0;
    sel_data = '0;
    sel_err  = 1'b0;
    for (int i = 0; i < NumCsr; i++) begin
      if (addr_q == AddrW'(i)) begin
        addr_ok  = 1'b1;
        sel_data = csr_rd_data_i[i*Width +: Width];
        sel_err  = csr_rd_error_i[i];
      end
    end
  end

  // New CSR value from the old value and the operand.
  always_comb begin
    new_val = wdata_q;
    case (op_q)
      OpSet:   new_val = sel_data | wdata_q;
      OpClear: new_val = sel_data & ~wdata_q;
      default: new_val = wdata_q;
    endcase
  end

  // Reads and zero-operand set/clear leave the CSR alone, so no strobe.
  assign need_wr = addr_ok && !sel_err &&
                   ((op_q == OpWrite) || (op_q[1] && (wdata_q != '0)));

`ifdef IBEX_CSR_SCRUB_EN
  localparam int              CntW   = $clog2(ScrubPeriod);
  localparam logic [CntW-1:0] CntMax = CntW'(ScrubPeriod - 1);

  logic [CntW-1:0]  idle_cnt_q;
  logic [AddrW-1:0] scrub_idx_q;
  logic             scrub_err;

  // Shadow-error flag of the entry due for a background check.
  always_comb begin
    scrub_err = 1'b0;
    for (int i = 0; i < NumCsr; i++) begin
      if (scrub_idx_q == AddrW'(i)) begin
        scrub_err = csr_rd_error_i[i];
      end
    end
  end
`endif

  // Sequencer: one request at a time, all outputs registered.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      op_q        <= '0;
      wdata_q     <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_error_q <= 1'b0;
      wr_en_q     <= '0;
      wr_data_q   <= '0;
      alert_q     <= 1'b0;
`ifdef IBEX_CSR_SCRUB_EN
      idle_cnt_q  <= '0;
      scrub_idx_q <= '0;
`endif
    end else begin
      alert_q <= 1'b0;
      wr_en_q <= '0;
      case (state_q)
        ST_IDLE: begin
          if (req_valid_i) begin
            // A request always wins over a due scrub; the counter stays put.
            addr_q      <= req_addr_i;
            op_q        <= req_op_i;
            wdata_q     <= req_wdata_i;
            req_ready_q <= 1'b0;
            state_q     <= ST_READ;
          end
`ifdef IBEX_CSR_SCRUB_EN
          else if (idle_cnt_q == CntMax) begin
            req_ready_q <= 1'b0;
            state_q     <= ST_SCRUB;
          end else begin
            idle_cnt_q <= idle_cnt_q + CntW'(1);
          end
`endif
        end
        ST_READ: begin
          rsp_rdata_q <= sel_data;
          rsp_error_q <= !addr_ok || sel_err;
          alert_q     <= addr_ok && sel_err;
          if (need_wr) begin
            wr_en_q   <= NumCsr'(1) << addr_q;
            wr_data_q <= new_val;
            state_q   <= ST_WRITE;
          end else begin
            rsp_valid_q <= 1'b1;
            state_q     <= ST_RESP;
          end
        end
        ST_WRITE: begin
          rsp_valid_q <= 1'b1;
          state_q     <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end
`ifdef IBEX_CSR_SCRUB_EN
        ST_SCRUB: begin
          // Scrub errors only raise the alert; nothing is reported on rsp.
          alert_q     <= scrub_err;
          scrub_idx_q <= (scrub_idx_q == AddrW'(NumCsr - 1)) ? '0
                                                              : scrub_idx_q + AddrW'(1);
          idle_cnt_q  <= '0;
          req_ready_q <= 1'b1;
          state_q     <= ST_IDLE;
        end
`endif
        default: begin
          rsp_valid_q <= 1'b0;
          req_ready_q <= 1'b1;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_ready_o   = req_ready_q;
  assign rsp_valid_o   = rsp_valid_q;
  assign rsp_rdata_o   = rsp_rdata_q;
  assign rsp_error_o   = rsp_error_q;
  assign csr_wr_en_o   = wr_en_q;
  assign csr_wr_data_o = wr_data_q;
  assign alert_o       = alert_q;

endmodule
